// File: rtl/instr_fetch_queue_if.sv
// Fetch-bus and issue-side signals of the instruction fetch queue.
// master = queue side; slave = memory controller / issue side.
interface instr_fetch_queue_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_data;
  logic        issue_stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        has_instr;
  logic [31:0] instr;
  logic [31:0] npc;

  modport master (
    output fetch_req, fetch_addr, has_instr, instr, npc,
    input  fetch_ack, fetch_data, issue_stall, flush, flush_pc
  );

  modport slave (
    input  fetch_req, fetch_addr, has_instr, instr, npc,
    output fetch_ack, fetch_data, issue_stall, flush, flush_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with a one-outstanding-request FSM feeding a
// show-ahead circular queue. Define IFQ_JAL_PREDICT_EN to follow JAL targets.
module instr_fetch_queue #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  input logic                 rdy_in,
  instr_fetch_queue_if.master bus
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DISCARD = 2'd2} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  fetch_req_r;
  logic                  req_nxt;
  logic [31:0]           fetch_addr_r;
  logic [31:0]           fetch_pc;
  logic [31:0]           fetch_pc_nxt;
  logic [31:0]           pred_pc;
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   count;
  logic                  launch;
  logic                  push;
  logic                  pop;
  logic                  clear;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] npc_mem   [DEPTH];

`ifdef IFQ_JAL_PREDICT_EN
  logic signed [31:0] imm_j;
  assign imm_j   = {{12{bus.fetch_data[31]}}, bus.fetch_data[19:12],
                    bus.fetch_data[20], bus.fetch_data[30:21], 1'b0};
  assign pred_pc = (bus.fetch_data[6:0] == 7'b1101111) ? fetch_pc + $unsigned(imm_j)
                                                       : fetch_pc + 32'd4;
`else
  assign pred_pc = fetch_pc + 32'd4;
`endif

  // A flush always wins; a request already on the bus must still be retired
  // by its ack, so WAIT moves to DISCARD unless that ack is arriving now.
  always_comb begin
    state_nxt    = state;
    req_nxt      = fetch_req_r;
    fetch_pc_nxt = fetch_pc;
    launch       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    clear        = 1'b0;
    if (rdy_in) begin
      clear = bus.flush;
      pop   = (count != '0) && !bus.issue_stall && !bus.flush;
      if (bus.flush) fetch_pc_nxt = bus.flush_pc;
      case (state)
        IDLE: begin
          if (!bus.flush && (count != CNT_FULL)) begin
            launch    = 1'b1;
            req_nxt   = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (bus.fetch_ack) begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
            if (!bus.flush) begin
              push         = 1'b1;
              fetch_pc_nxt = pred_pc;
            end
          end else if (bus.flush) begin
            state_nxt = DISCARD;
          end
        end
        DISCARD: begin
          if (bus.fetch_ack) begin
            req_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
        default: begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      fetch_req_r  <= 1'b0;
      fetch_addr_r <= RESET_PC;
      fetch_pc     <= RESET_PC;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
    end else begin
      state       <= state_nxt;
      fetch_req_r <= req_nxt;
      fetch_pc    <= fetch_pc_nxt;
      if (launch) fetch_addr_r <= fetch_pc;
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is data only; validity is carried entirely by count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      instr_mem[tail] <= bus.fetch_data;
      npc_mem[tail]   <= pred_pc;
    end
  end

  assign bus.fetch_req  = fetch_req_r;
  assign bus.fetch_addr = fetch_addr_r;
  assign bus.has_instr  = (count != '0);
  assign bus.instr      = (count != '0) ? instr_mem[head] : '0;
  assign bus.npc        = (count != '0) ? npc_mem[head]   : '0;

endmodule
